// File: rtl/bubble_sort_engine_pkg.sv
// Shared types and defaults for the bubble-sort engine.
// The optional swap counter is enabled by defining SORT_SWAP_COUNT_EN.
package bubble_sort_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } sort_state_t;

  // Width needed to hold the worst-case number of swaps, DEPTH*(DEPTH-1)/2.
  function automatic int swap_count_width(input int depth);
    return $clog2(depth * (depth - 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/bubble_sort_engine_cmp_swap.sv
// Combinational compare-and-swap for one adjacent pair of entries.
// lo_out goes to the lower index, hi_out to the higher index; ties never swap.
module cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             descending,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             swap
);

  // Order test and conditional exchange
  always_comb begin
    swap = 1'b0;
    if (descending) begin
      swap = (a < b);
    end else begin
      swap = (a > b);
    end
    lo_out = swap ? b : a;
    hi_out = swap ? a : b;
  end

endmodule

// File: rtl/bubble_sort_engine.sv
// In-place bubble-sort engine over DEPTH unsigned WIDTH-bit entries, early exit on a clean pass.
// Define SORT_SWAP_COUNT_EN to add the swap_count output.
module bubble_sort_engine
  import bubble_sort_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             start,
  input  logic             descending,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done
`ifdef SORT_SWAP_COUNT_EN
  ,
  output logic [swap_count_width(DEPTH)-1:0] swap_count
`endif
);

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  sort_state_t      state;
  sort_state_t      next_state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    idx;
  logic [AW-1:0]    idx_nxt;
  logic [AW-1:0]    bound;
  logic             swapped;
  logic             desc_lat;
  logic             addr_ok;
  logic             last_cmp;
  logic             pass_swapped;
  logic [WIDTH-1:0] lo_val;
  logic [WIDTH-1:0] hi_val;
  logic             swap;

  assign idx_nxt      = idx + AW'(1);
  assign addr_ok      = ({1'b0, addr} < DEPTH_W);
  assign last_cmp     = (idx == bound - AW'(1));
  assign pass_swapped = swapped | swap;
  assign rd_data      = addr_ok ? mem[addr] : {WIDTH{1'b0}};

  cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
    .a          (mem[idx]),
    .b          (mem[idx_nxt]),
    .descending (desc_lat),
    .lo_out     (lo_val),
    .hi_out     (hi_val),
    .swap       (swap)
  );

  // Next-state decode; a pass ends on its last compare
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SORT;
        end else begin
          next_state = IDLE;
        end
      end
      SORT: begin
        if (last_cmp && (!pass_swapped || bound == AW'(1))) begin
          next_state = DONE;
        end else begin
          next_state = SORT;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == SORT);
      done  <= (next_state == DONE);
    end
  end

  // Array, pass index, pass bound, swap flag and latched order
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= {WIDTH{1'b0}};
      end
      idx      <= {AW{1'b0}};
      bound    <= {AW{1'b0}};
      swapped  <= 1'b0;
      desc_lat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en && addr_ok) begin
            mem[addr] <= wr_data;
          end
          if (start) begin
            desc_lat <= descending;
            idx      <= {AW{1'b0}};
            bound    <= LAST_IDX;
            swapped  <= 1'b0;
          end
        end
        SORT: begin
          if (swap) begin
            mem[idx]     <= lo_val;
            mem[idx_nxt] <= hi_val;
          end
          if (last_cmp) begin
            idx     <= {AW{1'b0}};
            bound   <= bound - AW'(1);
            swapped <= 1'b0;
          end else begin
            idx     <= idx_nxt;
            swapped <= pass_swapped;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SORT_SWAP_COUNT_EN
  localparam int SCW = swap_count_width(DEPTH);

  // Swap counter: cleared on an accepted start, held after done
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      swap_count <= {SCW{1'b0}};
    end else if (state == IDLE && start) begin
      swap_count <= {SCW{1'b0}};
    end else if (state == SORT && swap) begin
      swap_count <= swap_count + SCW'(1);
    end else begin
      swap_count <= swap_count;
    end
  end
`endif

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Self-checking bench for bubble_sort_engine: directed cases plus random arrays
// checked against an array-level model (sorted order, inversion count, pass count).
module tb_bubble_sort_engine;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             CLOCK_50 = 1'b0;
  logic             rst_n;
  logic             start;
  logic             descending;
  logic             wr_en;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
`ifdef SORT_SWAP_COUNT_EN
  logic [4:0]       swap_count;
`endif

  int checks = 0;
  int errors = 0;
  int vals [DEPTH];
  int exp_sorted [DEPTH];
  int exp_lat;
  int exp_swaps;

  bubble_sort_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .start      (start),
    .descending (descending),
    .wr_en      (wr_en),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done)
`ifdef SORT_SWAP_COUNT_EN
    ,
    .swap_count (swap_count)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: final order, swaps = strict inversions, passes = max displacement + 1 clean pass.
  task automatic build_model(input bit desc);
    int q[$];
    int p;
    int c;
    int passes;
    q = {};
    for (int k = 0; k < DEPTH; k++) q.push_back(vals[k]);
    if (desc) q.rsort(); else q.sort();
    for (int k = 0; k < DEPTH; k++) exp_sorted[k] = q[k];
    p = 0;
    exp_swaps = 0;
    for (int j = 0; j < DEPTH; j++) begin
      c = 0;
      for (int i = 0; i < j; i++)
        if (desc ? (vals[i] < vals[j]) : (vals[i] > vals[j])) c++;
      exp_swaps += c;
      if (c > p) p = c;
    end
    passes  = (p + 1 < DEPTH - 1) ? p + 1 : DEPTH - 1;
    exp_lat = 1;
    for (int k = 1; k <= passes; k++) exp_lat += DEPTH - k;
  endtask

  task automatic load_vals();
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge CLOCK_50);
      wr_en   = 1'b1;
      addr    = AW'(k);
      wr_data = WIDTH'(vals[k]);
    end
    @(negedge CLOCK_50);
    wr_en = 1'b0;
  endtask

  task automatic read_back(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      addr = AW'(k);
      #1;
      check($sformatf("%s_rd%0d", tag, k), 32'(rd_data), 32'(exp_sorted[k]));
    end
  endtask

  // Start a sort, optionally inject a write+start mid-sort and a start during DONE.
  task automatic run_sort(input string tag, input bit desc, input int inject, input bit poke_done);
    int cycles;
    build_model(desc);
    @(negedge CLOCK_50);
    start      = 1'b1;
    descending = desc;
    cycles     = 0;
    do begin
      @(negedge CLOCK_50);
      cycles++;
      start = 1'b0;
      wr_en = 1'b0;
      if (cycles == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (inject != 0 && cycles == inject) begin
        wr_en   = 1'b1;
        addr    = '0;
        wr_data = 8'd255;
        start   = 1'b1;
      end
    end while (done !== 1'b1 && cycles < 200);
    check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
    if (poke_done) start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    @(negedge CLOCK_50);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    read_back(tag);
`ifdef SORT_SWAP_COUNT_EN
    check({tag, "_swap_count"}, 32'(swap_count), 32'(exp_swaps));
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    descending = 1'b0;
    wr_en      = 1'b0;
    addr       = '0;
    wr_data    = '0;
    repeat (3) @(negedge CLOCK_50);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    for (int k = 0; k < DEPTH; k++) exp_sorted[k] = 0;
    read_back("reset");
    rst_n = 1'b1;

    vals = '{5, 3, 8, 1, 9, 2, 7, 4};
    load_vals();
    run_sort("asc", 1'b0, 0, 1'b0);
    check("asc_latency_bound", 32'(exp_lat <= 29), 32'd1);

    vals = '{5, 3, 8, 1, 9, 2, 7, 4};
    load_vals();
    run_sort("desc", 1'b1, 0, 1'b1);

    vals = '{1, 2, 3, 4, 5, 6, 7, 8};
    load_vals();
    run_sort("sorted", 1'b0, 0, 1'b0);
    check("sorted_lat8", 32'(exp_lat), 32'd8);

    vals = '{8, 7, 6, 5, 4, 3, 2, 1};
    load_vals();
    run_sort("reverse", 1'b0, 0, 1'b0);
    check("reverse_swaps28", 32'(exp_swaps), 32'd28);

    vals = '{4, 4, 2, 2, 6, 6, 1, 1};
    load_vals();
    run_sort("midwrite", 1'b0, 3, 1'b0);

    // Reset in the middle of a sort
    vals = '{8, 7, 6, 5, 4, 3, 2, 1};
    load_vals();
    @(negedge CLOCK_50);
    start = 1'b1;
    repeat (5) begin
      @(negedge CLOCK_50);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    for (int k = 0; k < DEPTH; k++) exp_sorted[k] = 0;
    read_back("rst_mid");
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    vals = '{5, 3, 8, 1, 9, 2, 7, 4};
    load_vals();
    run_sort("after_rst", 1'b0, 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < DEPTH; k++) vals[k] = int'($urandom_range(0, 15)) * ((r % 3 == 0) ? 17 : 1);
      load_vals();
      run_sort($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bubble_sort_engine.md
Name: bubble_sort_engine

Overview:
Parametrised in-place bubble-sort engine holding DEPTH unsigned WIDTH-bit entries in an internal register array.
- Host loads entries, pulses start, waits for done, then reads back sorted data.
- Supports ascending/descending mode and early exit when a pass makes no swaps.
- Sits under the board-level bubble_sort top, which maps SW/KEY to load/start and drives HEX/LEDR from rd_data/status.

Parameters:
WIDTH, 8, bit width of each entry (unsigned compare)
DEPTH, 8, number of entries; legal range 2..256
AW, $clog2(DEPTH), address width (derived; not overridden)

Ports:
CLOCK_50  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin sorting; honoured only in IDLE
descending  input  1  sort order, sampled when start is accepted; 0 = ascending, 1 = descending
wr_en  input  1  write strobe for loading entries; honoured only in IDLE
addr  input  AW  shared write/read index
wr_data  input  WIDTH  data written to mem[addr]
rd_data  output  WIDTH  combinational mem[addr], valid in every state
busy  output  1  high in SORT
done  output  1  one-cycle pulse when sorting completes

Behaviour:
Reset (async, rst_n low):
- All mem entries = 0.
- State = IDLE; busy = 0; done = 0.
- Internal index, pass bound, swap flag and latched order cleared.

States: IDLE, SORT, DONE.

IDLE:
- wr_en=1 writes wr_data to mem[addr] at the clock edge.
- If addr >= DEPTH (non-power-of-2 DEPTH), the write is dropped and rd_data = 0.
- start=1 latches descending, sets i=0, bound=DEPTH-1, swapped=0, and moves to SORT.
- wr_en and start in the same cycle: the write commits on that edge, and the sort operates on the updated array.

SORT: one compare-and-swap per cycle on mem[i] vs mem[i+1].
- Swap condition: ascending swaps if mem[i] > mem[i+1]; descending swaps if mem[i] < mem[i+1].
- Equal entries never swap (stable).
- Any swap sets swapped.
- If i < bound-1: i increments.
- If i == bound-1 (last compare of the pass), including this cycle's swap result:
  - no swap in the pass, or bound == 1 → DONE;
  - else i=0, bound decrements, swapped cleared, stay in SORT.
- start and wr_en are ignored; a mid-sort write never corrupts the array.

DONE:
- done=1 for exactly one cycle, busy=0, then IDLE.
- A start asserted during DONE is ignored.

Latency (start edge to done high):
- Already sorted: DEPTH-1 SORT cycles + 1.
- Worst case (reverse order): DEPTH*(DEPTH-1)/2 SORT cycles + 1.
- For DEPTH=8: 8 and 29 cycles respectively.

Reset mid-sort: immediate return to IDLE with a cleared array; no done pulse.

Optional Feature:
Macro SORT_SWAP_COUNT_EN.
- Defined: adds output swap_count, width $clog2(DEPTH*(DEPTH-1)/2+1).
  - Cleared when start is accepted.
  - Increments once per performed swap.
  - Holds its value after done until the next accepted start.
  - 0 on reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
Package bubble_sort_pkg holds:
- typedef enum logic [1:0] {IDLE, SORT, DONE} sort_state_t;
- default WIDTH/DEPTH constants shared with the top level.

Natural sub-module cmp_swap: purely combinational. Inputs are a, b and descending; outputs are lo_out, hi_out and swap. The engine instantiates it once on mem[i]/mem[i+1].

Test Plan:
1. Load [5,3,8,1,9,2,7,4], ascending start → done after ≤29 cycles; read back [1,2,3,4,5,7,8,9].
2. Same data, descending=1 → [9,8,7,5,4,3,2,1].
3. Load [1,2,3,4,5,6,7,8], ascending → done exactly 8 cycles after start (early exit); array unchanged; swap_count=0 if enabled.
4. Load [8,7,6,5,4,3,2,1], ascending → done exactly 29 cycles after start; swap_count=28 if enabled.
5. Load [4,4,2,2,...]; during SORT assert wr_en addr=0 data=255 and pulse start → both ignored; result sorted, no 255, single done pulse.
6. Deassert rst_n mid-sort → busy=0 and done=0 immediately; all rd_data=0; a subsequent load and sort works normally.
